// File: rtl/sad_pkg.sv
// Shared types and constants for the minimum-SAD collector.
package sad_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REDUCE  = 2'd1,
    DONE    = 2'd2
  } sad_state_e;

  localparam int SAD_W_DEF   = 32;
  localparam int COORD_W_DEF = 8;

  localparam logic [SAD_W_DEF-1:0] SAD_INIT = '1;

endpackage

// File: rtl/sad_cmp_sel.sv
// Strict-less compare of one buffered candidate against the running minimum,
// selecting the winning (sad, row, col, core) tuple. Ties keep the running value.
module sad_cmp_sel #(
  parameter int SAD_W   = 32,
  parameter int COORD_W = 8,
  parameter int IDX_W   = 3
) (
  input  logic [SAD_W-1:0]   cand_sad_i,
  input  logic [COORD_W-1:0] cand_row_i,
  input  logic [COORD_W-1:0] cand_col_i,
  input  logic [IDX_W-1:0]   cand_core_i,
  input  logic [SAD_W-1:0]   run_sad_i,
  input  logic [COORD_W-1:0] run_row_i,
  input  logic [COORD_W-1:0] run_col_i,
  input  logic [IDX_W-1:0]   run_core_i,
  output logic [SAD_W-1:0]   sel_sad_o,
  output logic [COORD_W-1:0] sel_row_o,
  output logic [COORD_W-1:0] sel_col_o,
  output logic [IDX_W-1:0]   sel_core_o
);

  logic take;

  assign take       = (cand_sad_i < run_sad_i);
  assign sel_sad_o  = take ? cand_sad_i  : run_sad_i;
  assign sel_row_o  = take ? cand_row_i  : run_row_i;
  assign sel_col_o  = take ? cand_col_i  : run_col_i;
  assign sel_core_o = take ? cand_core_i : run_core_i;

endmodule

// File: rtl/sad_min_collector.sv
// Buffers one SAD result per core, scans the slots one per cycle for the global
// minimum and registers the winner. SAD_MIN_ZERO_EXIT_EN ends the scan on a zero SAD.
module sad_min_collector
  import sad_pkg::*;
#(
  parameter int NUM_CORES     = 8,
  parameter int SAD_W         = SAD_W_DEF,
  parameter int COORD_W       = COORD_W_DEF,
  parameter int ROWS_PER_CORE = 8
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           frame_start,
  input  logic [NUM_CORES-1:0]           core_valid,
  input  logic [NUM_CORES*SAD_W-1:0]     core_sad,
  input  logic [NUM_CORES*COORD_W-1:0]   core_row,
  input  logic [NUM_CORES*COORD_W-1:0]   core_col,
  output logic [SAD_W-1:0]               best_sad,
  output logic [COORD_W-1:0]             best_row,
  output logic [COORD_W-1:0]             best_col,
  output logic [$clog2(NUM_CORES)-1:0]   best_core,
  output logic                           result_valid,
  output logic                           busy,
  output logic                           drop_err,
  output sad_state_e                     state_dbg
);

  localparam int IDX_W = $clog2(NUM_CORES);

  sad_state_e               state_q, state_d;
  logic [NUM_CORES-1:0]     pending_q, pending_d;
  logic [NUM_CORES-1:0]     buf_we;
  logic                     drop_err_q, drop_err_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SAD_W-1:0]         run_sad_q, run_sad_d, best_sad_q, best_sad_d;
  logic [COORD_W-1:0]       run_row_q, run_row_d, best_row_q, best_row_d;
  logic [COORD_W-1:0]       run_col_q, run_col_d, best_col_q, best_col_d;
  logic [IDX_W-1:0]         run_core_q, run_core_d, best_core_q, best_core_d;

  logic [SAD_W-1:0]         sad_buf_q [NUM_CORES];
  logic [COORD_W-1:0]       row_buf_q [NUM_CORES];
  logic [COORD_W-1:0]       col_buf_q [NUM_CORES];

  logic [COORD_W-1:0]       cand_row;
  logic [SAD_W-1:0]         sel_sad;
  logic [COORD_W-1:0]       sel_row, sel_col;
  logic [IDX_W-1:0]         sel_core;
  logic                     last_slot, zero_hit, accept;

  // Core-local row becomes a frame row; the sum wraps at COORD_W bits.
  assign cand_row  = row_buf_q[idx_q] + COORD_W'(int'(idx_q) * ROWS_PER_CORE);
  assign last_slot = (idx_q == IDX_W'(NUM_CORES - 1));

  sad_cmp_sel #(
    .SAD_W   (SAD_W),
    .COORD_W (COORD_W),
    .IDX_W   (IDX_W)
  ) u_cmp_sel (
    .cand_sad_i  (sad_buf_q[idx_q]),
    .cand_row_i  (cand_row),
    .cand_col_i  (col_buf_q[idx_q]),
    .cand_core_i (idx_q),
    .run_sad_i   (run_sad_q),
    .run_row_i   (run_row_q),
    .run_col_i   (run_col_q),
    .run_core_i  (run_core_q),
    .sel_sad_o   (sel_sad),
    .sel_row_o   (sel_row),
    .sel_col_o   (sel_col),
    .sel_core_o  (sel_core)
  );

`ifdef SAD_MIN_ZERO_EXIT_EN
  // A zero running minimum can only come from this cycle's slot: zero exits at once.
  assign zero_hit = (sel_sad == '0);
`else
  assign zero_hit = 1'b0;
`endif

  // frame_start forces collection behaviour this cycle, so its valids still latch.
  assign accept = frame_start || (state_q == COLLECT);

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    drop_err_d  = drop_err_q;
    idx_d       = idx_q;
    run_sad_d   = run_sad_q;
    run_row_d   = run_row_q;
    run_col_d   = run_col_q;
    run_core_d  = run_core_q;
    best_sad_d  = best_sad_q;
    best_row_d  = best_row_q;
    best_col_d  = best_col_q;
    best_core_d = best_core_q;
    buf_we      = '0;
    if (accept) begin
      buf_we    = core_valid;
      pending_d = (frame_start ? '0 : pending_q) | core_valid;
      if (frame_start) drop_err_d = 1'b0;
      state_d = COLLECT;
      if (&pending_d) begin
        state_d    = REDUCE;
        idx_d      = '0;
        run_sad_d  = '1;
        run_core_d = '0;
      end
    end else begin
      if (|core_valid) drop_err_d = 1'b1;
      if (state_q == REDUCE) begin
        run_sad_d  = sel_sad;
        run_row_d  = sel_row;
        run_col_d  = sel_col;
        run_core_d = sel_core;
        idx_d      = idx_q + 1'b1;
        if (last_slot || zero_hit) begin
          state_d     = DONE;
          best_sad_d  = sel_sad;
          best_row_d  = sel_row;
          best_col_d  = sel_col;
          best_core_d = sel_core;
        end
      end else begin
        pending_d = '0;
        state_d   = COLLECT;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= COLLECT;
      pending_q   <= '0;
      drop_err_q  <= 1'b0;
      idx_q       <= '0;
      run_sad_q   <= '1;
      run_row_q   <= '0;
      run_col_q   <= '0;
      run_core_q  <= '0;
      best_sad_q  <= '1;
      best_row_q  <= '0;
      best_col_q  <= '0;
      best_core_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      drop_err_q  <= drop_err_d;
      idx_q       <= idx_d;
      run_sad_q   <= run_sad_d;
      run_row_q   <= run_row_d;
      run_col_q   <= run_col_d;
      run_core_q  <= run_core_d;
      best_sad_q  <= best_sad_d;
      best_row_q  <= best_row_d;
      best_col_q  <= best_col_d;
      best_core_q <= best_core_d;
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < NUM_CORES; k++) begin
      if (buf_we[k]) begin
        sad_buf_q[k] <= core_sad[k*SAD_W +: SAD_W];
        row_buf_q[k] <= core_row[k*COORD_W +: COORD_W];
        col_buf_q[k] <= core_col[k*COORD_W +: COORD_W];
      end
    end
  end

  assign best_sad     = best_sad_q;
  assign best_row     = best_row_q;
  assign best_col     = best_col_q;
  assign best_core    = best_core_q;
  assign result_valid = (state_q == DONE);
  assign busy         = (state_q != COLLECT);
  assign drop_err     = drop_err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_sad_min_collector.sv
// Directed bench for sad_min_collector: a vector table of full frames plus
// hand-written multi-cycle sequences (staggered arrival, drop, abort, reset).
module tb_sad_min_collector;
  import sad_pkg::*;

  localparam int NC = 8;
  localparam int SW = 32;
  localparam int CW = 8;

  logic              clk;
  logic              rst_n;
  logic              frame_start;
  logic [NC-1:0]     core_valid;
  logic [NC*SW-1:0]  core_sad;
  logic [NC*CW-1:0]  core_row;
  logic [NC*CW-1:0]  core_col;
  logic [SW-1:0]     best_sad;
  logic [CW-1:0]     best_row;
  logic [CW-1:0]     best_col;
  logic [2:0]        best_core;
  logic              result_valid;
  logic              busy;
  logic              drop_err;
  sad_state_e        state_dbg;

  sad_min_collector dut (
    .Clk          (clk),
    .Rst          (rst_n),
    .frame_start  (frame_start),
    .core_valid   (core_valid),
    .core_sad     (core_sad),
    .core_row     (core_row),
    .core_col     (core_col),
    .best_sad     (best_sad),
    .best_row     (best_row),
    .best_col     (best_col),
    .best_core    (best_core),
    .result_valid (result_valid),
    .busy         (busy),
    .drop_err     (drop_err),
    .state_dbg    (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [NC*SW-1:0] sad;
    logic [NC*CW-1:0] row;
    logic [NC*CW-1:0] col;
    logic [SW-1:0]    e_sad;
    logic [CW-1:0]    e_row;
    logic [CW-1:0]    e_col;
    logic [2:0]       e_core;
    int               e_lat;
  } vec_t;

  vec_t vecs[5];
  int   n_pass  = 0;
  int   n_total = 0;

  // scoreboard helper
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // driver tasks
  task automatic idle();
    core_valid  = '0;
    frame_start = 1'b0;
  endtask

  task automatic set_core(input int k, input logic [SW-1:0] s, input logic [CW-1:0] r,
                          input logic [CW-1:0] c);
    core_valid[k]         = 1'b1;
    core_sad[k*SW +: SW]  = s;
    core_row[k*CW +: CW]  = r;
    core_col[k*CW +: CW]  = c;
  endtask

  task automatic wait_result(input int start, output int lat);
    logic fin;
    fin = 1'b0;
    lat = start;
    while (!fin) begin
      @(negedge clk);
      lat++;
      idle();
      if (result_valid) fin = 1'b1;
      else if (lat >= 40) begin
        n_total++;
        $display("FAIL result_timeout: no result_valid after %0d cycles, required within 40", lat);
        fin = 1'b1;
      end
    end
  endtask

  task automatic no_result(input int n, input string nm);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      idle();
      if (result_valid) seen = 1'b1;
    end
    chk(nm, seen, 1'b0);
  endtask

  task automatic chk_best(input string nm, input logic [SW-1:0] s, input logic [CW-1:0] r,
                          input logic [CW-1:0] c, input logic [2:0] k);
    chk({nm, "_sad"},  best_sad,  s);
    chk({nm, "_row"},  best_row,  r);
    chk({nm, "_col"},  best_col,  c);
    chk({nm, "_core"}, best_core, k);
  endtask

  initial begin
    int   lat;
    logic early;

    // core 7 is the leftmost element of every packed literal
    vecs[0].sad = {32'd90, 32'd80, 32'd70, 32'd60, 32'd20, 32'd30, 32'd40, 32'd50};
    vecs[0].row = {8'd1, 8'd1, 8'd1, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1};
    vecs[0].col = {8'd9, 8'd9, 8'd9, 8'd9, 8'd5, 8'd9, 8'd9, 8'd9};
    vecs[0].e_sad = 32'd20; vecs[0].e_row = 8'd26; vecs[0].e_col = 8'd5;
    vecs[0].e_core = 3'd3; vecs[0].e_lat = 9;

    vecs[1].sad = {32'd100, 32'd7, 32'd100, 32'd100, 32'd100, 32'd7, 32'd100, 32'd100};
    vecs[1].row = {8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd4, 8'd0, 8'd0};
    vecs[1].col = {8'd0, 8'd12, 8'd0, 8'd0, 8'd0, 8'd11, 8'd0, 8'd0};
    vecs[1].e_sad = 32'd7; vecs[1].e_row = 8'd20; vecs[1].e_col = 8'd11;
    vecs[1].e_core = 3'd2; vecs[1].e_lat = 9;

    vecs[2].sad = {32'd1, {7{32'd1000}}};
    vecs[2].row = {8'd250, 56'd0};
    vecs[2].col = {8'd200, 56'd0};
    vecs[2].e_sad = 32'd1; vecs[2].e_row = 8'd50; vecs[2].e_col = 8'd200;
    vecs[2].e_core = 3'd7; vecs[2].e_lat = 9;

    vecs[3].sad = {{7{32'hFFFF_FFFF}}, 32'hFFFF_FFFE};
    vecs[3].row = {56'd0, 8'd3};
    vecs[3].col = {56'd0, 8'd4};
    vecs[3].e_sad = 32'hFFFF_FFFE; vecs[3].e_row = 8'd3; vecs[3].e_col = 8'd4;
    vecs[3].e_core = 3'd0; vecs[3].e_lat = 9;

    vecs[4].sad = {{6{32'd10}}, 32'd0, 32'd10};
    vecs[4].row = {48'd0, 8'd7, 8'd0};
    vecs[4].col = {48'd0, 8'd3, 8'd0};
    vecs[4].e_sad = 32'd0; vecs[4].e_row = 8'd15; vecs[4].e_col = 8'd3;
    vecs[4].e_core = 3'd1;
`ifdef SAD_MIN_ZERO_EXIT_EN
    vecs[4].e_lat = 3;
`else
    vecs[4].e_lat = 9;
`endif

    rst_n = 1'b0;
    idle();
    core_sad = '0;
    core_row = '0;
    core_col = '0;
    repeat (3) @(negedge clk);
    chk_best("reset", SAD_INIT, 8'd0, 8'd0, 3'd0);
    chk("reset_result_valid", result_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_drop_err", drop_err, 1'b0);
    chk("reset_state", state_dbg, COLLECT);
    rst_n = 1'b1;
    @(negedge clk);

    // table: full frames, each driven the cycle after the previous result
    for (int i = 0; i < 5; i++) begin
      core_valid = '1;
      core_sad   = vecs[i].sad;
      core_row   = vecs[i].row;
      core_col   = vecs[i].col;
      wait_result(0, lat);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      chk_best($sformatf("v%0d", i), vecs[i].e_sad, vecs[i].e_row, vecs[i].e_col, vecs[i].e_core);
      chk($sformatf("v%0d_busy_done", i), busy, 1'b1);
      @(negedge clk);
      idle();
      chk($sformatf("v%0d_pulse", i), result_valid, 1'b0);
      chk($sformatf("v%0d_drop_err", i), drop_err, 1'b0);
    end

    // staggered arrival, core 4 reports twice (last one wins)
    early = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(negedge clk);
        idle();
        if (busy || result_valid) early = 1'b1;
      end
      if (c == 4) set_core(4, 32'd9, 8'd1, 8'd2);
      else set_core(c, 32'(50 + c), 8'd1, 8'd2);
      if (c == 6) set_core(4, 32'd3, 8'd1, 8'd6);
    end
    wait_result(0, lat);
    chk("stagger_early", early, 1'b0);
    chk("stagger_latency", lat, 9);
    chk_best("stagger", 32'd3, 8'd33, 8'd6, 3'd4);
    @(negedge clk);
    idle();

    // valid during REDUCE is dropped and flagged
    core_valid = '1;
    core_sad   = vecs[0].sad;
    core_row   = vecs[0].row;
    core_col   = vecs[0].col;
    @(negedge clk);
    idle();
    set_core(1, 32'd0, 8'd0, 8'd0);
    wait_result(1, lat);
    chk("drop_latency", lat, 9);
    chk_best("drop", 32'd20, 8'd26, 8'd5, 3'd3);
    chk("drop_err_set", drop_err, 1'b1);
    @(negedge clk);
    idle();
    frame_start = 1'b1;
    @(negedge clk);
    idle();
    chk("drop_err_cleared", drop_err, 1'b0);

    // frame_start in REDUCE cycle 4 aborts the scan
    core_valid = '1;
    core_sad   = vecs[1].sad;
    core_row   = vecs[1].row;
    core_col   = vecs[1].col;
    repeat (3) begin
      @(negedge clk);
      idle();
    end
    @(negedge clk);
    idle();
    frame_start = 1'b1;
    @(negedge clk);
    idle();
    chk("abort_busy", busy, 1'b0);
    no_result(12, "abort_no_result");
    chk_best("abort_hold", 32'd20, 8'd26, 8'd5, 3'd3);
    for (int k = 0; k < 7; k++) set_core(k, 32'd40, 8'd0, 8'd0);
    no_result(12, "abort_pending_cleared");
    set_core(7, 32'd5, 8'd0, 8'd1);
    wait_result(0, lat);
    chk("abort_next_latency", lat, 9);
    chk_best("abort_next", 32'd5, 8'd56, 8'd1, 3'd7);

    // frame_start with valids in the same cycle: clear first, then latch
    @(negedge clk);
    idle();
    for (int k = 0; k < 4; k++) set_core(k, 32'd1, 8'd0, 8'd0);
    @(negedge clk);
    idle();
    frame_start = 1'b1;
    for (int k = 4; k < 8; k++) set_core(k, 32'(60 + k - 4), 8'd0, 8'd0);
    no_result(6, "fs_valid_no_result");
    for (int k = 0; k < 4; k++) set_core(k, 32'd70, 8'd0, 8'd0);
    wait_result(0, lat);
    chk("fs_valid_latency", lat, 9);
    chk_best("fs_valid", 32'd60, 8'd32, 8'd0, 3'd4);

    // asynchronous reset in the middle of REDUCE
    @(negedge clk);
    idle();
    core_valid = '1;
    core_sad   = vecs[2].sad;
    core_row   = vecs[2].row;
    core_col   = vecs[2].col;
    @(negedge clk);
    idle();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_state", state_dbg, COLLECT);
    chk_best("async_rst", SAD_INIT, 8'd0, 8'd0, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_valid = '1;
    core_sad   = vecs[0].sad;
    core_row   = vecs[0].row;
    core_col   = vecs[0].col;
    wait_result(0, lat);
    chk("post_rst_latency", lat, 9);
    chk("post_rst_sad", best_sad, 32'd20);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
